// File: rtl/axi4_lite_master_engine.sv
// axi4_lite_master_engine
//   AXI4-Lite master. Each single-cycle WR_START or RD_START request becomes
//   one complete AXI transaction: AW/W/B for a write, AR/R for a read.
//   Only one transaction is in flight at a time. A busy-cycle timeout aborts
//   the transaction if the slave hangs.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   WR_START/ADDR/DATA/STRB     write request, sampled while IDLE
//   RD_START/ADDR               read request, sampled while IDLE
//                               (a write wins when both starts arrive together)
//   IDLE                        high when a new start will be accepted
//   RESP_VALID/DATA/CODE        one-cycle completion pulse, read data, response code
//   TIMED_OUT                   qualifies RESP_VALID when the transaction was aborted
//   AXI_*                       AXI4-Lite master channels AW, W, B, AR, R
//
// state    | meaning
// S_IDLE   | waiting for a start request
// S_WRITE  | AW and W in flight, each tracked on its own
// S_WAIT_B | BREADY high, waiting for the write response
// S_READ   | ARVALID high, waiting for ARREADY
// S_WAIT_R | RREADY high, waiting for read data
module axi4_lite_master_engine #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          WR_START,
  input  logic [AXI_ADDR_WIDTH-1:0]     WR_ADDR,
  input  logic [AXI_DATA_WIDTH-1:0]     WR_DATA,
  input  logic [AXI_DATA_WIDTH/8-1:0]   WR_STRB,
  input  logic                          RD_START,
  input  logic [AXI_ADDR_WIDTH-1:0]     RD_ADDR,
  output logic                          IDLE,
  output logic                          RESP_VALID,
  output logic [AXI_DATA_WIDTH-1:0]     RESP_DATA,
  output logic [1:0]                    RESP_CODE,
  output logic                          TIMED_OUT,
  output logic [AXI_ADDR_WIDTH-1:0]     AXI_AWADDR,
  output logic                          AXI_AWVALID,
  input  logic                          AXI_AWREADY,
  output logic [AXI_DATA_WIDTH-1:0]     AXI_WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0]   AXI_WSTRB,
  output logic                          AXI_WVALID,
  input  logic                          AXI_WREADY,
  input  logic [1:0]                    AXI_BRESP,
  input  logic                          AXI_BVALID,
  output logic                          AXI_BREADY,
  output logic [AXI_ADDR_WIDTH-1:0]     AXI_ARADDR,
  output logic                          AXI_ARVALID,
  input  logic                          AXI_ARREADY,
  input  logic [AXI_DATA_WIDTH-1:0]     AXI_RDATA,
  input  logic [1:0]                    AXI_RRESP,
  input  logic                          AXI_RVALID,
  output logic                          AXI_RREADY
);

  localparam int SW = AXI_DATA_WIDTH / 8;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_WAIT_B, S_READ, S_WAIT_R} state_t;

  state_t                state_q;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, araddr_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, resp_data_q;
  logic [SW-1:0]         wstrb_q;
  logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                  resp_valid_q, timed_out_q;
  logic [1:0]            resp_code_q;
  logic [CW-1:0]         tmo_cnt_q, tmo_cnt_d;
  logic                  tmo_hit;

  // tmo_cnt_q holds busy cycles already completed, so the abort fires at the
  // edge that closes the TIMEOUT_CYCLES-th busy cycle.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    tmo_hit   = 1'b0;
    if (TIMEOUT_CYCLES > 0 && state_q != S_IDLE) begin
      if (tmo_cnt_q != CNT_MAX) tmo_cnt_d = tmo_cnt_q + 1'b1;
      tmo_hit = (tmo_cnt_q == TO_LAST);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      awaddr_q     <= '0;
      araddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      timed_out_q  <= 1'b0;
      resp_code_q  <= 2'b00;
      resp_data_q  <= '0;
      tmo_cnt_q    <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      timed_out_q  <= 1'b0;
      tmo_cnt_q    <= tmo_cnt_d;
      if (tmo_hit) begin
        // Abort outranks any handshake completing in this same cycle.
        awvalid_q    <= 1'b0;
        wvalid_q     <= 1'b0;
        bready_q     <= 1'b0;
        arvalid_q    <= 1'b0;
        rready_q     <= 1'b0;
        resp_valid_q <= 1'b1;
        timed_out_q  <= 1'b1;
        resp_code_q  <= 2'b10;
        resp_data_q  <= '0;
        tmo_cnt_q    <= '0;
        state_q      <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            tmo_cnt_q <= '0;
            if (WR_START) begin
              awaddr_q  <= WR_ADDR;
              wdata_q   <= WR_DATA;
              wstrb_q   <= WR_STRB;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= S_WRITE;
            end else if (RD_START) begin
              araddr_q  <= RD_ADDR;
              arvalid_q <= 1'b1;
              state_q   <= S_READ;
            end
          end
          S_WRITE: begin
            if (awvalid_q && AXI_AWREADY) awvalid_q <= 1'b0;
            if (wvalid_q && AXI_WREADY)   wvalid_q  <= 1'b0;
            // Each channel is done if it already dropped or is handshaking now.
            if ((!awvalid_q || AXI_AWREADY) && (!wvalid_q || AXI_WREADY)) begin
              bready_q <= 1'b1;
              state_q  <= S_WAIT_B;
            end
          end
          S_WAIT_B: begin
            if (AXI_BVALID) begin
              bready_q     <= 1'b0;
              resp_valid_q <= 1'b1;
              resp_code_q  <= AXI_BRESP;
              resp_data_q  <= '0;
              tmo_cnt_q    <= '0;
              state_q      <= S_IDLE;
            end
          end
          S_READ: begin
            if (AXI_ARREADY) begin
              arvalid_q <= 1'b0;
              rready_q  <= 1'b1;
              state_q   <= S_WAIT_R;
            end
          end
          S_WAIT_R: begin
            if (AXI_RVALID) begin
              rready_q     <= 1'b0;
              resp_valid_q <= 1'b1;
              resp_code_q  <= AXI_RRESP;
              resp_data_q  <= AXI_RDATA;
              tmo_cnt_q    <= '0;
              state_q      <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign IDLE        = (state_q == S_IDLE);
  assign RESP_VALID  = resp_valid_q;
  assign RESP_DATA   = resp_data_q;
  assign RESP_CODE   = resp_code_q;
  assign TIMED_OUT   = timed_out_q;
  assign AXI_AWADDR  = awaddr_q;
  assign AXI_AWVALID = awvalid_q;
  assign AXI_WDATA   = wdata_q;
  assign AXI_WSTRB   = wstrb_q;
  assign AXI_WVALID  = wvalid_q;
  assign AXI_BREADY  = bready_q;
  assign AXI_ARADDR  = araddr_q;
  assign AXI_ARVALID = arvalid_q;
  assign AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi4_lite_master_engine.sv
// Directed bench for axi4_lite_master_engine. The bench acts as the slave
// and checks the master's outputs cycle by cycle against hand-computed values.
module tb_axi4_lite_master_engine;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk, reset;
  logic          WR_START, RD_START;
  logic [AW-1:0] WR_ADDR, RD_ADDR;
  logic [DW-1:0] WR_DATA;
  logic [3:0]    WR_STRB;
  logic          IDLE, RESP_VALID, TIMED_OUT;
  logic [DW-1:0] RESP_DATA;
  logic [1:0]    RESP_CODE;
  logic [AW-1:0] AXI_AWADDR, AXI_ARADDR;
  logic          AXI_AWVALID, AXI_AWREADY;
  logic [DW-1:0] AXI_WDATA;
  logic [3:0]    AXI_WSTRB;
  logic          AXI_WVALID, AXI_WREADY;
  logic [1:0]    AXI_BRESP;
  logic          AXI_BVALID, AXI_BREADY;
  logic          AXI_ARVALID, AXI_ARREADY;
  logic [DW-1:0] AXI_RDATA;
  logic [1:0]    AXI_RRESP;
  logic          AXI_RVALID, AXI_RREADY;

  int n_checks = 0;
  int n_fail   = 0;

  axi4_lite_master_engine #(
    .AXI_DATA_WIDTH(DW),
    .AXI_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset),
    .WR_START(WR_START), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_STRB(WR_STRB),
    .RD_START(RD_START), .RD_ADDR(RD_ADDR),
    .IDLE(IDLE), .RESP_VALID(RESP_VALID), .RESP_DATA(RESP_DATA),
    .RESP_CODE(RESP_CODE), .TIMED_OUT(TIMED_OUT),
    .AXI_AWADDR(AXI_AWADDR), .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
    .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WVALID(AXI_WVALID),
    .AXI_WREADY(AXI_WREADY),
    .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
    .AXI_ARADDR(AXI_ARADDR), .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
    .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP), .AXI_RVALID(AXI_RVALID),
    .AXI_RREADY(AXI_RREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_quiet();
    AXI_AWREADY = 0; AXI_WREADY = 0; AXI_BVALID = 0; AXI_BRESP = 2'b00;
    AXI_ARREADY = 0; AXI_RVALID = 0; AXI_RDATA = '0; AXI_RRESP = 2'b00;
  endtask

  initial begin
    reset = 1; WR_START = 0; RD_START = 0;
    WR_ADDR = '0; WR_DATA = '0; WR_STRB = '0; RD_ADDR = '0;
    slave_quiet();
    tick(); tick();
    check_val("rst_idle", IDLE, 1);
    check_val("rst_awvalid", AXI_AWVALID, 0);
    check_val("rst_arvalid", AXI_ARVALID, 0);
    check_val("rst_resp_valid", RESP_VALID, 0);
    check_val("rst_resp_code", RESP_CODE, 0);
    reset = 0;
    tick();

    // Write, slave always ready
    AXI_AWREADY = 1; AXI_WREADY = 1; AXI_BVALID = 1; AXI_BRESP = 2'b00;
    WR_START = 1; WR_ADDR = 32'h1000; WR_DATA = 32'hDEADBEEF; WR_STRB = 4'hF;
    tick(); WR_START = 0;                                     // cycle 1
    check_val("w1_awvalid", AXI_AWVALID, 1);
    check_val("w1_wvalid", AXI_WVALID, 1);
    check_val("w1_awaddr", AXI_AWADDR, 32'h1000);
    check_val("w1_wdata", AXI_WDATA, 32'hDEADBEEF);
    check_val("w1_wstrb", AXI_WSTRB, 4'hF);
    check_val("w1_idle", IDLE, 0);
    tick();                                                    // cycle 2
    check_val("w2_awvalid", AXI_AWVALID, 0);
    check_val("w2_bready", AXI_BREADY, 1);
    check_val("w2_resp_valid", RESP_VALID, 0);
    tick();                                                    // cycle 3
    check_val("w3_resp_valid", RESP_VALID, 1);
    check_val("w3_resp_code", RESP_CODE, 0);
    check_val("w3_resp_data", RESP_DATA, 0);
    check_val("w3_idle", IDLE, 1);
    check_val("w3_timed_out", TIMED_OUT, 0);
    tick();                                                    // cycle 4
    check_val("w4_resp_valid", RESP_VALID, 0);
    check_val("w4_bready", AXI_BREADY, 0);
    slave_quiet();

    // Read with ARREADY stalled
    AXI_RVALID = 1; AXI_RDATA = 32'h12345678; AXI_RRESP = 2'b00;
    RD_START = 1; RD_ADDR = 32'h2000;
    tick(); RD_START = 0;
    for (int c = 1; c <= 3; c++) begin
      check_val("r_arvalid_held", AXI_ARVALID, 1);
      check_val("r_araddr_stable", AXI_ARADDR, 32'h2000);
      check_val("r_no_rready", AXI_RREADY, 0);
      if (c == 3) AXI_ARREADY = 1;
      else tick();
    end
    tick(); AXI_ARREADY = 0;                                   // cycle 4
    check_val("r4_arvalid", AXI_ARVALID, 0);
    check_val("r4_rready", AXI_RREADY, 1);
    check_val("r4_resp_valid", RESP_VALID, 0);
    tick();                                                    // cycle 5
    check_val("r5_resp_valid", RESP_VALID, 1);
    check_val("r5_resp_data", RESP_DATA, 32'h12345678);
    check_val("r5_resp_code", RESP_CODE, 0);
    check_val("r5_rready", AXI_RREADY, 0);
    tick();
    check_val("r6_resp_valid", RESP_VALID, 0);
    slave_quiet();

    // Split write handshakes: W at cycle 1, AW at cycle 4, BRESP=SLVERR
    WR_START = 1; WR_ADDR = 32'h3000; WR_DATA = 32'hA5A5A5A5; WR_STRB = 4'h3;
    tick(); WR_START = 0; AXI_WREADY = 1;                      // cycle 1
    check_val("s1_wvalid", AXI_WVALID, 1);
    check_val("s1_wstrb", AXI_WSTRB, 4'h3);
    tick(); AXI_WREADY = 0;                                    // cycle 2
    check_val("s2_wvalid", AXI_WVALID, 0);
    check_val("s2_awvalid", AXI_AWVALID, 1);
    check_val("s2_bready", AXI_BREADY, 0);
    tick();                                                    // cycle 3
    check_val("s3_awvalid", AXI_AWVALID, 1);
    tick(); AXI_AWREADY = 1;                                   // cycle 4
    check_val("s4_awvalid", AXI_AWVALID, 1);
    check_val("s4_awaddr", AXI_AWADDR, 32'h3000);
    check_val("s4_bready", AXI_BREADY, 0);
    tick(); AXI_AWREADY = 0;                                   // cycle 5
    check_val("s5_awvalid", AXI_AWVALID, 0);
    check_val("s5_bready", AXI_BREADY, 1);
    AXI_BVALID = 1; AXI_BRESP = 2'b10;
    tick();                                                    // cycle 6
    check_val("s6_resp_valid", RESP_VALID, 1);
    check_val("s6_resp_code", RESP_CODE, 2'b10);
    check_val("s6_bready", AXI_BREADY, 0);
    slave_quiet();
    tick();

    // Arbitration, busy start ignored, back-to-back start
    AXI_AWREADY = 1; AXI_WREADY = 1; AXI_BVALID = 1; AXI_BRESP = 2'b00;
    AXI_ARREADY = 1; AXI_RVALID = 1; AXI_RDATA = 32'hCAFEF00D; AXI_RRESP = 2'b00;
    WR_START = 1; WR_ADDR = 32'h3100; WR_DATA = 32'h11; WR_STRB = 4'h1;
    RD_START = 1; RD_ADDR = 32'h3200;
    tick(); WR_START = 0;                                      // cycle 1, RD_START held while busy
    check_val("a1_awvalid", AXI_AWVALID, 1);
    check_val("a1_arvalid", AXI_ARVALID, 0);
    tick(); RD_START = 0;                                      // cycle 2
    check_val("a2_arvalid", AXI_ARVALID, 0);
    check_val("a2_resp_valid", RESP_VALID, 0);
    tick();                                                    // cycle 3
    check_val("a3_resp_valid", RESP_VALID, 1);
    check_val("a3_resp_data", RESP_DATA, 0);
    check_val("a3_arvalid", AXI_ARVALID, 0);
    check_val("a3_idle", IDLE, 1);
    RD_START = 1; RD_ADDR = 32'h4000;
    tick(); RD_START = 0;                                      // cycle 4
    check_val("b2b_arvalid", AXI_ARVALID, 1);
    check_val("b2b_araddr", AXI_ARADDR, 32'h4000);
    check_val("b2b_resp_valid", RESP_VALID, 0);
    tick();                                                    // cycle 5
    check_val("b2b_rready", AXI_RREADY, 1);
    tick();                                                    // cycle 6
    check_val("b2b_resp_valid2", RESP_VALID, 1);
    check_val("b2b_resp_data", RESP_DATA, 32'hCAFEF00D);
    slave_quiet();
    tick();

    // Timeout: AWREADY never arrives
    WR_START = 1; WR_ADDR = 32'h5000; WR_DATA = 32'h55; WR_STRB = 4'hF;
    tick(); WR_START = 0;                                      // cycle 1
    for (int c = 1; c <= 16; c++) begin
      check_val("t_no_resp", RESP_VALID, 0);
      check_val("t_awvalid", AXI_AWVALID, 1);
      tick();
    end                                                        // now cycle 17
    check_val("t17_resp_valid", RESP_VALID, 1);
    check_val("t17_timed_out", TIMED_OUT, 1);
    check_val("t17_resp_code", RESP_CODE, 2'b10);
    check_val("t17_resp_data", RESP_DATA, 0);
    check_val("t17_awvalid", AXI_AWVALID, 0);
    check_val("t17_wvalid", AXI_WVALID, 0);
    check_val("t17_idle", IDLE, 1);
    tick();
    check_val("t18_resp_valid", RESP_VALID, 0);
    check_val("t18_timed_out", TIMED_OUT, 0);
    check_val("t18_idle", IDLE, 1);

    // Reset mid-read while RREADY is high
    AXI_ARREADY = 1;
    RD_START = 1; RD_ADDR = 32'h6000;
    tick(); RD_START = 0;                                      // cycle 1
    check_val("m1_arvalid", AXI_ARVALID, 1);
    tick();                                                    // cycle 2
    check_val("m2_rready", AXI_RREADY, 1);
    #2 reset = 1;
    #1;
    check_val("m_rst_rready", AXI_RREADY, 0);
    check_val("m_rst_arvalid", AXI_ARVALID, 0);
    check_val("m_rst_idle", IDLE, 1);
    check_val("m_rst_araddr", AXI_ARADDR, 0);
    check_val("m_rst_resp_code", RESP_CODE, 0);
    #1 reset = 0;
    tick();
    AXI_RVALID = 1; AXI_RDATA = 32'h0BADCAFE; AXI_RRESP = 2'b01;
    RD_START = 1; RD_ADDR = 32'h7000;
    tick(); RD_START = 0;                                      // cycle 1
    check_val("f1_araddr", AXI_ARADDR, 32'h7000);
    tick();                                                    // cycle 2
    check_val("f2_rready", AXI_RREADY, 1);
    tick();                                                    // cycle 3
    check_val("f3_resp_valid", RESP_VALID, 1);
    check_val("f3_resp_data", RESP_DATA, 32'h0BADCAFE);
    check_val("f3_resp_code", RESP_CODE, 2'b01);
    slave_quiet();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
